// File: rtl/control_unit_pkg.sv
// Shared symbols for the control unit: opcodes, step encodings, ALU mode codes and the
// decoded control word passed from instr_decoder to control_unit.
package control_unit_pkg;

  typedef enum logic [3:0] {
    OpNop = 4'h0,
    OpLda = 4'h1,
    OpAdd = 4'h2,
    OpSub = 4'h3,
    OpSta = 4'h4,
    OpLdi = 4'h5,
    OpJmp = 4'h6,
    OpJc  = 4'h7,
    OpJz  = 4'h8,
    OpAdc = 4'h9,
    OpAnd = 4'hA,
    OpOr  = 4'hB,
    OpXor = 4'hC,
    OpInc = 4'hD,
    OpOut = 4'hE,
    OpHlt = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    StepT0 = 3'd0,
    StepT1 = 3'd1,
    StepT2 = 3'd2,
    StepT3 = 3'd3,
    StepT4 = 3'd4,
    StepT5 = 3'd5
  } step_e;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluAdc = 3'b001;
  localparam logic [2:0] AluSub = 3'b010;
  localparam logic [2:0] AluInc = 3'b011;
  localparam logic [2:0] AluAnd = 3'b101;
  localparam logic [2:0] AluOr  = 3'b110;
  localparam logic [2:0] AluXor = 3'b111;

  // Full decoded control word. last/set_halt/ir_load are internal sequencing controls.
  typedef struct packed {
    logic       pc_out;
    logic       pc_inc;
    logic       pc_load;
    logic       mar_load;
    logic       ram_out;
    logic       ram_in;
    logic       ir_out;
    logic       ir_load;
    logic       a_out;
    logic       a_load;
    logic       b_load;
    logic       out_load;
    logic       alu_ee;
    logic       alu_eo;
    logic       halt;
    logic [2:0] alu_mode;
    logic       last;
    logic       set_halt;
  } ctrl_t;

  // Two-operand ALU instructions fetch their second operand from RAM.
  function automatic logic is_alu2(input opcode_e op);
    return op inside {OpAdd, OpSub, OpAdc, OpAnd, OpOr, OpXor};
  endfunction

  function automatic logic [2:0] alu_code(input opcode_e op);
    logic [2:0] code;
    code = AluAdd;
    case (op)
      OpAdc:   code = AluAdc;
      OpSub:   code = AluSub;
      OpInc:   code = AluInc;
      OpAnd:   code = AluAnd;
      OpOr:    code = AluOr;
      OpXor:   code = AluXor;
      default: code = AluAdd;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_unit_instr_decoder.sv
// instr_decoder: purely combinational microcode decode.
// Ports:
//   opcode     - ir[7:4] of the current instruction
//   step       - current step T0..T5
//   flag_zero  - ALU zero flag (used by JZ in T2)
//   flag_carry - ALU carry flag (used by JC in T2)
//   halted     - processor is halted; only halt is asserted
//   ctrl       - decoded control word
module instr_decoder
  import control_unit_pkg::*;
(
  input  logic [3:0] opcode,
  input  step_e      step,
  input  logic       flag_zero,
  input  logic       flag_carry,
  input  logic       halted,
  output ctrl_t      ctrl
);

  opcode_e op;
  assign op = opcode_e'(opcode);

  always_comb begin
    ctrl = '0;
    if (halted) begin
      ctrl.halt = 1'b1;
    end else begin
      case (step)
        StepT0: begin
          ctrl.pc_out   = 1'b1;
          ctrl.mar_load = 1'b1;
        end
        // NOP termination is decided by the top from the fetched byte.
        StepT1: begin
          ctrl.ram_out = 1'b1;
          ctrl.ir_load = 1'b1;
          ctrl.pc_inc  = 1'b1;
        end
        StepT2: begin
          case (op)
            OpLda, OpSta, OpAdd, OpSub, OpAdc, OpAnd, OpOr, OpXor: begin
              ctrl.ir_out   = 1'b1;
              ctrl.mar_load = 1'b1;
            end
            OpLdi: begin
              ctrl.ir_out = 1'b1;
              ctrl.a_load = 1'b1;
              ctrl.last   = 1'b1;
            end
            OpJmp: begin
              ctrl.ir_out  = 1'b1;
              ctrl.pc_load = 1'b1;
              ctrl.last    = 1'b1;
            end
            OpJc: begin
              ctrl.ir_out  = 1'b1;
              ctrl.pc_load = flag_carry;
              ctrl.last    = 1'b1;
            end
            OpJz: begin
              ctrl.ir_out  = 1'b1;
              ctrl.pc_load = flag_zero;
              ctrl.last    = 1'b1;
            end
            OpOut: begin
              ctrl.a_out    = 1'b1;
              ctrl.out_load = 1'b1;
              ctrl.last     = 1'b1;
            end
            OpInc: begin
              ctrl.alu_ee   = 1'b1;
              ctrl.alu_mode = AluInc;
            end
            OpHlt:   ctrl.set_halt = 1'b1;
            default: ctrl.last = 1'b1;
          endcase
        end
        StepT3: begin
          if (op == OpLda) begin
            ctrl.ram_out = 1'b1;
            ctrl.a_load  = 1'b1;
            ctrl.last    = 1'b1;
          end else if (op == OpSta) begin
            ctrl.a_out  = 1'b1;
            ctrl.ram_in = 1'b1;
            ctrl.last   = 1'b1;
          end else if (op == OpInc) begin
            ctrl.alu_eo = 1'b1;
            ctrl.a_load = 1'b1;
            ctrl.last   = 1'b1;
          end else if (is_alu2(op)) begin
            ctrl.ram_out = 1'b1;
            ctrl.b_load  = 1'b1;
          end else begin
            ctrl.last = 1'b1;
          end
        end
        StepT4: begin
          if (is_alu2(op)) begin
            ctrl.alu_ee   = 1'b1;
            ctrl.alu_mode = alu_code(op);
          end else begin
            ctrl.last = 1'b1;
          end
        end
        StepT5: begin
          if (is_alu2(op)) begin
            ctrl.alu_eo = 1'b1;
            ctrl.a_load = 1'b1;
          end
          ctrl.last = 1'b1;
        end
        // Encodings 6/7 are unreachable; recover to T0 if ever seen.
        default: ctrl.last = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: microcoded sequencer for an 8-bit bus-based CPU. Holds the instruction
// register, step counter and halted flag; instr_decoder produces the control word.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   bus                   - shared data bus; driven with {4'h0, ir[3:0]} only while ir_out
//   flag_zero, flag_carry - ALU flags for conditional jumps
//   pc_out .. halt        - one-bit control strobes
//   alu_mode              - ALU operation code (000 whenever alu_ee is low)
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] bus,
  input  logic       flag_zero,
  input  logic       flag_carry,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ram_in,
  output logic       ir_out,
  output logic       a_out,
  output logic       a_load,
  output logic       b_load,
  output logic       out_load,
  output logic       alu_ee,
  output logic       alu_eo,
  output logic       halt,
  output logic [2:0] alu_mode
);

  step_e      step_q, step_d;
  logic [7:0] ir_q, ir_d;
  logic       halted_q, halted_d;
  ctrl_t      ctrl, ctrl_g;

  instr_decoder u_instr_decoder (
    .opcode     (ir_q[7:4]),
    .step       (step_q),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .halted     (halted_q),
    .ctrl       (ctrl)
  );

  // Reset silences every output in the same cycle, whatever state is held.
  assign ctrl_g = rst ? '0 : ctrl;

  assign pc_out   = ctrl_g.pc_out;
  assign pc_inc   = ctrl_g.pc_inc;
  assign pc_load  = ctrl_g.pc_load;
  assign mar_load = ctrl_g.mar_load;
  assign ram_out  = ctrl_g.ram_out;
  assign ram_in   = ctrl_g.ram_in;
  assign ir_out   = ctrl_g.ir_out;
  assign a_out    = ctrl_g.a_out;
  assign a_load   = ctrl_g.a_load;
  assign b_load   = ctrl_g.b_load;
  assign out_load = ctrl_g.out_load;
  assign alu_ee   = ctrl_g.alu_ee;
  assign alu_eo   = ctrl_g.alu_eo;
  assign halt     = ctrl_g.halt;
  assign alu_mode = ctrl_g.alu_mode;

  assign bus = ir_out ? {4'h0, ir_q[3:0]} : 8'hzz;

  always_comb begin
    step_d   = step_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (ctrl.ir_load) begin
        // NOP must finish after T1, so peek at the byte being latched. This feeds
        // next-state only, never an output.
        ir_d   = bus;
        step_d = (opcode_e'(bus[7:4]) == OpNop) ? StepT0 : StepT2;
      end else if (ctrl.set_halt) begin
        halted_d = 1'b1;
      end else if (ctrl.last) begin
        step_d = StepT0;
      end else begin
        step_d = step_e'(step_q + 3'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= StepT0;
      ir_q     <= 8'h00;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit with a per-cycle expected-control scoreboard.
module tb_control_unit;

  typedef struct packed {
    logic       pc_out;
    logic       pc_inc;
    logic       pc_load;
    logic       mar_load;
    logic       ram_out;
    logic       ram_in;
    logic       ir_out;
    logic       a_out;
    logic       a_load;
    logic       b_load;
    logic       out_load;
    logic       alu_ee;
    logic       alu_eo;
    logic       halt;
    logic [2:0] alu_mode;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flag_zero = 1'b0;
  logic       flag_carry = 1'b0;
  logic [7:0] fetch_val = 8'h00;
  wire  [7:0] bus;
  logic pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_out;
  logic a_out, a_load, b_load, out_load, alu_ee, alu_eo, halt;
  logic [2:0] alu_mode;

  int   total = 0;
  int   bad = 0;
  ctl_t exp_q[$];
  ctl_t obs;

  always #5 clk = ~clk;

  control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .pc_out     (pc_out),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .mar_load   (mar_load),
    .ram_out    (ram_out),
    .ram_in     (ram_in),
    .ir_out     (ir_out),
    .a_out      (a_out),
    .a_load     (a_load),
    .b_load     (b_load),
    .out_load   (out_load),
    .alu_ee     (alu_ee),
    .alu_eo     (alu_eo),
    .halt       (halt),
    .alu_mode   (alu_mode)
  );

  // Stand-in for the other bus drivers: RAM returns the instruction under test.
  logic       tb_en;
  logic [7:0] tb_val;
  always_comb begin
    tb_en  = 1'b1;
    tb_val = 8'h00;
    if (ram_out)     tb_val = fetch_val;
    else if (pc_out) tb_val = 8'h10;
    else if (a_out)  tb_val = 8'h55;
    else if (alu_eo) tb_val = 8'hAA;
    else             tb_en  = 1'b0;
  end
  assign bus = tb_en ? tb_val : 8'hzz;

  assign obs = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_out, a_out, a_load,
                b_load, out_load, alu_ee, alu_eo, halt, alu_mode};

  function automatic logic [2:0] mode_of(input logic [3:0] op);
    case (op)
      4'h9:    return 3'b001;
      4'h3:    return 3'b010;
      4'hA:    return 3'b101;
      4'hB:    return 3'b110;
      4'hC:    return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int n_steps(input logic [3:0] op);
    case (op)
      4'h0:                         return 2;
      4'h1, 4'h4, 4'hD:             return 4;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: return 3;
      default:                      return 6;
    endcase
  endfunction

  function automatic ctl_t model(input logic [7:0] ins, input int step, input logic fc,
                                 input logic fz);
    ctl_t       e;
    logic [3:0] op;
    e  = '0;
    op = ins[7:4];
    if (step == 0) begin
      e.pc_out = 1'b1; e.mar_load = 1'b1;
    end else if (step == 1) begin
      e.ram_out = 1'b1; e.pc_inc = 1'b1;
    end else begin
      case (op)
        4'h1: if (step == 2) begin e.ir_out = 1'b1; e.mar_load = 1'b1; end
              else begin e.ram_out = 1'b1; e.a_load = 1'b1; end
        4'h4: if (step == 2) begin e.ir_out = 1'b1; e.mar_load = 1'b1; end
              else begin e.a_out = 1'b1; e.ram_in = 1'b1; end
        4'h5: begin e.ir_out = 1'b1; e.a_load = 1'b1; end
        4'h6: begin e.ir_out = 1'b1; e.pc_load = 1'b1; end
        4'h7: begin e.ir_out = 1'b1; e.pc_load = fc; end
        4'h8: begin e.ir_out = 1'b1; e.pc_load = fz; end
        4'hE: begin e.a_out = 1'b1; e.out_load = 1'b1; end
        4'hD: if (step == 2) begin e.alu_ee = 1'b1; e.alu_mode = 3'b011; end
              else begin e.alu_eo = 1'b1; e.a_load = 1'b1; end
        4'h2, 4'h3, 4'h9, 4'hA, 4'hB, 4'hC: begin
          case (step)
            2:       begin e.ir_out = 1'b1; e.mar_load = 1'b1; end
            3:       begin e.ram_out = 1'b1; e.b_load = 1'b1; end
            4:       begin e.alu_ee = 1'b1; e.alu_mode = mode_of(op); end
            default: begin e.alu_eo = 1'b1; e.a_load = 1'b1; end
          endcase
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic check_cycle(input string tag, input logic [7:0] ins, input int step);
    ctl_t e;
    int   drivers;
    e = exp_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s step=%0d ctl observed=%h expected=%h", tag, step, obs, e);
    end
    drivers = $countones({pc_out, ram_out, ir_out, a_out, alu_eo});
    total++;
    assert (drivers <= 1) else begin
      bad++;
      $error("FAIL %s_excl step=%0d drivers observed=%0d expected<=1", tag, step, drivers);
    end
    if (e.ir_out) begin
      total++;
      assert (bus === {4'h0, ins[3:0]}) else begin
        bad++;
        $error("FAIL %s_bus step=%0d bus observed=%h expected=%h", tag, step, bus,
               {4'h0, ins[3:0]});
      end
    end
  endtask

  // Called in the low phase of the cycle where the DUT sits in T0.
  task automatic run_instr(input string tag, input logic [7:0] ins, input logic fc,
                           input logic fz, input int abort_step);
    int n;
    n          = n_steps(ins[7:4]);
    fetch_val  = ins;
    flag_carry = fc;
    flag_zero  = fz;
    for (int s = 0; s < n; s++) begin
      if (s == abort_step) begin
        exp_q.push_back('0);
        break;
      end
      exp_q.push_back(model(ins, s, fc, fz));
    end
    for (int s = 0; s < n; s++) begin
      if (s == abort_step) rst = 1'b1;
      #1;
      check_cycle(tag, ins, s);
      @(negedge clk);
      if (s == abort_step) begin
        rst = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    ctl_t hw;
    // Two reset cycles: everything silent.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp_q.push_back('0);
      #1;
      check_cycle("reset", 8'h00, 0);
    end
    rst = 1'b0;

    run_instr("ldi57", 8'h57, 1'b0, 1'b0, -1);
    run_instr("add2e", 8'h2E, 1'b0, 1'b0, -1);
    run_instr("jc_nc", 8'h7A, 1'b0, 1'b0, -1);
    run_instr("jc_c", 8'h7A, 1'b1, 1'b0, -1);
    run_instr("nop", 8'h00, 1'b0, 1'b0, -1);
    run_instr("abort_add", 8'h2E, 1'b0, 1'b0, 4);
    run_instr("after_abort", 8'h13, 1'b0, 1'b0, -1);

    // Every opcode except HLT under every flag combination.
    for (int op = 0; op < 15; op++) begin
      for (int f = 0; f < 4; f++) begin
        logic [7:0] ins;
        ins = {4'(op), 4'($urandom_range(0, 15))};
        run_instr("sweep", ins, f[1], f[0], -1);
      end
    end

    run_instr("hlt", 8'hF0, 1'b1, 1'b1, -1);
    hw      = '0;
    hw.halt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      flag_carry = 1'($urandom_range(0, 1));
      flag_zero  = 1'($urandom_range(0, 1));
      exp_q.push_back(hw);
      #1;
      check_cycle("halted", 8'hF0, 2);
      @(negedge clk);
    end
    rst = 1'b1;
    exp_q.push_back('0);
    #1;
    check_cycle("halt_rst", 8'hF0, 2);
    @(negedge clk);
    rst = 1'b0;
    run_instr("resume", 8'hE0, 1'b0, 1'b0, -1);
    run_instr("resume2", 8'h5C, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
